button_pio_debounced: RTL and testbench

Parametrised Avalon-MM input PIO for push-buttons and switches, successor to the single-bit edge-capture PIO in the timer/display subsystem. It synchronises and debounces `WIDTH` independent inputs, and detects rising and/or falling edges per bit under software control. Each bit latches edges in a write-1-to-clear capture register and raises a maskable level interrupt. It sits on the Nios II data bus beside the timer and display peripherals.

---
 rtl/button_pio_debounced.sv | 64 ++++++
 tb/tb_button_pio_debounced.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/button_pio_debounced.sv
// button_pio_debounced: synchronised, debounced Avalon-MM input PIO with
// per-bit rise/fall edge capture (write-1-to-clear) and a maskable level irq.
module button_pio_debounced #(
  parameter int WIDTH = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] INIT_LEVEL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] s1, s2, stable, rise_en, fall_en, irq_mask, edge_capture;
  logic [WIDTH-1:0] upd, edge_ev, clr;
  logic [CW-1:0]    cnt [WIDTH];
  logic             wr;
  logic [31:0]      rd_mux;
  assign wr      = chipselect && !write_n;
  assign edge_ev = upd & ((s2 & rise_en) | (~s2 & fall_en));
  assign clr     = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  assign irq     = |(edge_capture & irq_mask);
  always_comb begin
    upd = '0;
    for (int i = 0; i < WIDTH; i++) upd[i] = (s2[i] != stable[i]) && (cnt[i] == CMAX);
  end
  always_comb begin
    rd_mux = address == 2'd0 ? 32'(stable) :
             address == 2'd1 ? ((32'(fall_en) << 16) | 32'(rise_en)) :
             address == 2'd2 ? 32'(irq_mask) : 32'(edge_capture);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1           <= INIT_LEVEL;
      s2           <= INIT_LEVEL;
      stable       <= INIT_LEVEL;
      rise_en      <= '0;
      fall_en      <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      readdata     <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      s1     <= in_port;
      s2     <= s1;
      // upd is only ever set where s2 differs from stable, so toggling applies s2
      stable <= stable ^ upd;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= (s2[i] == stable[i] || upd[i]) ? '0 : cnt[i] + CW'(1);
      if (wr && address == 2'd1) begin
        rise_en <= writedata[WIDTH-1:0];
        fall_en <= writedata[16 +: WIDTH];
      end
      if (wr && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
      edge_capture <= edge_ev | (edge_capture & ~clr);
      readdata     <= rd_mux;
    end
  end
endmodule

// File: tb/tb_button_pio_debounced.sv
// tb_button_pio_debounced: directed scenarios for the debounced PIO with
// DEBOUNCE_CYCLES=4, WIDTH=4, INIT_LEVEL=0.
module tb_button_pio_debounced;
  logic        clk = 0;
  logic        reset_n = 1;
  logic [1:0]  address = 0;
  logic        chipselect = 0;
  logic        write_n = 1;
  logic [31:0] writedata = 0;
  logic [3:0]  in_port = 0;
  logic [31:0] readdata;
  logic        irq;
  int          checks = 0;
  int          fails = 0;

  button_pio_debounced #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .INIT_LEVEL(4'b0000)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1; write_n = 0;
    @(negedge clk);
    chipselect = 0; write_n = 1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    #3 reset_n = 0;
    #2;
    checks++; if (readdata !== 32'h0) begin fails++; $display("FAIL reset_readdata: got %h expected %h", readdata, 32'h0); end
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b expected 0", irq); end
    @(negedge clk); reset_n = 1;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      checks++; if (d !== 32'h0) begin fails++; $display("FAIL reset_read_addr%0d: got %h expected %h", a, d, 32'h0); end
    end
  endtask

  task automatic test_rising;
    logic [31:0] d;
    wr(1, 32'h0000_0001);
    wr(2, 32'h1);
    @(negedge clk); in_port[0] = 1;
    repeat (5) @(negedge clk);
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL rise_irq_before_E5: got %b expected 0", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin fails++; $display("FAIL rise_irq_after_E5: got %b expected 1", irq); end
    rd(3, d);
    checks++; if (d !== 32'h1) begin fails++; $display("FAIL rise_capture: got %h expected %h", d, 32'h1); end
    rd(0, d);
    checks++; if (d !== 32'h1) begin fails++; $display("FAIL rise_data: got %h expected %h", d, 32'h1); end
    wr(3, 32'h1);
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL rise_clear_irq: got %b expected 0", irq); end
  endtask

  task automatic test_glitch;
    logic [31:0] d;
    wr(1, 32'h0000_0003);
    wr(2, 32'h3);
    @(negedge clk); in_port[1] = 1;
    repeat (3) @(negedge clk);
    in_port[1] = 0;
    repeat (10) @(negedge clk);
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL glitch_irq: got %b expected 0", irq); end
    rd(0, d);
    checks++; if (d !== 32'h1) begin fails++; $display("FAIL glitch_data: got %h expected %h", d, 32'h1); end
    rd(3, d);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL glitch_capture: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_falling_only;
    logic [31:0] d;
    wr(1, 32'h0004_0000);
    wr(2, 32'h4);
    @(negedge clk); in_port[2] = 1;
    repeat (10) @(negedge clk);
    rd(3, d);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL fall_rise_capture: got %h expected %h", d, 32'h0); end
    rd(0, d);
    checks++; if (d !== 32'h5) begin fails++; $display("FAIL fall_high_data: got %h expected %h", d, 32'h5); end
    in_port[2] = 0;
    repeat (10) @(negedge clk);
    checks++; if (irq !== 1'b1) begin fails++; $display("FAIL fall_irq: got %b expected 1", irq); end
    rd(3, d);
    checks++; if (d !== 32'h4) begin fails++; $display("FAIL fall_capture: got %h expected %h", d, 32'h4); end
    rd(1, d);
    checks++; if (d !== 32'h0004_0000) begin fails++; $display("FAIL fall_cfg_read: got %h expected %h", d, 32'h0004_0000); end
  endtask

  task automatic test_reg_widths;
    logic [31:0] d;
    wr(1, 32'hFFFF_FFFF);
    rd(1, d);
    checks++; if (d !== 32'h000F_000F) begin fails++; $display("FAIL width_cfg: got %h expected %h", d, 32'h000F_000F); end
    wr(2, 32'hFFFF_FFFF);
    rd(2, d);
    checks++; if (d !== 32'hF) begin fails++; $display("FAIL width_mask: got %h expected %h", d, 32'hF); end
    wr(0, 32'hFFFF_FFFF);
    rd(0, d);
    checks++; if (d !== 32'h1) begin fails++; $display("FAIL data_readonly: got %h expected %h", d, 32'h1); end
    wr(1, 0);
    wr(2, 0);
  endtask

  task automatic test_collision;
    logic [31:0] d;
    wr(3, 32'hF);
    wr(1, 32'h0001_0009);
    wr(2, 32'h8);
    @(negedge clk); in_port[0] = 0;
    repeat (6) @(negedge clk);
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL coll_pre_irq: got %b expected 0", irq); end
    rd(3, d);
    checks++; if (d !== 32'h1) begin fails++; $display("FAIL coll_pre_capture: got %h expected %h", d, 32'h1); end
    @(negedge clk); in_port[3] = 1;
    repeat (5) @(negedge clk);
    address = 3; writedata = 32'hF; chipselect = 1; write_n = 0;
    @(negedge clk);
    chipselect = 0; write_n = 1;
    checks++; if (irq !== 1'b1) begin fails++; $display("FAIL coll_irq: got %b expected 1", irq); end
    rd(3, d);
    checks++; if (d !== 32'h8) begin fails++; $display("FAIL coll_capture: got %h expected %h", d, 32'h8); end
    rd(0, d);
    checks++; if (d !== 32'h8) begin fails++; $display("FAIL coll_data: got %h expected %h", d, 32'h8); end
    wr(2, 0);
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL coll_unmask_irq: got %b expected 0", irq); end
  endtask

  task automatic test_masking;
    logic [31:0] d;
    wr(3, 32'hF);
    wr(1, 32'h0000_0003);
    @(negedge clk); in_port[1:0] = 2'b11;
    repeat (8) @(negedge clk);
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL mask_zero_irq: got %b expected 0", irq); end
    rd(3, d);
    checks++; if (d !== 32'h3) begin fails++; $display("FAIL mask_capture: got %h expected %h", d, 32'h3); end
    wr(2, 32'h2);
    checks++; if (irq !== 1'b1) begin fails++; $display("FAIL mask_set_irq: got %b expected 1", irq); end
    wr(3, 32'h2);
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL mask_clear_irq: got %b expected 0", irq); end
    rd(3, d);
    checks++; if (d !== 32'h1) begin fails++; $display("FAIL mask_capture_after: got %h expected %h", d, 32'h1); end
  endtask

  task automatic test_mid_reset;
    logic [31:0] d;
    wr(2, 32'h1);
    checks++; if (irq !== 1'b1) begin fails++; $display("FAIL mid_pre_irq: got %b expected 1", irq); end
    @(negedge clk); in_port[2] = 1;
    repeat (2) @(negedge clk);
    #2 reset_n = 0;
    #1;
    checks++; if (readdata !== 32'h0) begin fails++; $display("FAIL mid_readdata: got %h expected %h", readdata, 32'h0); end
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL mid_irq: got %b expected 0", irq); end
    in_port = 0;
    @(negedge clk); reset_n = 1;
    repeat (8) @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      checks++; if (d !== 32'h0) begin fails++; $display("FAIL mid_read_addr%0d: got %h expected %h", a, d, 32'h0); end
    end
  endtask

  initial begin
    test_reset;
    test_rising;
    test_glitch;
    test_falling_only;
    test_reg_widths;
    test_collision;
    test_masking;
    test_mid_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule
